// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one synchronous RAM between the fetch and data ports.
// Latency: gnt is combinational from req in the same cycle; read rvalid follows one cycle after gnt.
// Backpressure: a requester that loses holds its request; it wins the next contended cycle.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_e;

    grant_e last_grant;
    logic   arb_en;  // held low through the first edge after reset release

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (arb_en && !reset) begin
            if (if_req && d_req) begin
                if_gnt = (last_grant == GRANT_D);
                d_gnt  = (last_grant == GRANT_IF);
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    assign mem_addr = d_gnt ? d_addr : if_addr;
    assign mem_we   = d_we & d_gnt & ~reset;
    assign mem_data = d_wdata;

    // The RAM's registered address makes q line up with the cycle rvalid is high.
    assign if_rdata = mem_q;
    assign d_rdata  = mem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_D;
            arb_en     <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
        end else begin
            arb_en <= 1'b1;
            if (if_req && if_gnt) begin
                last_grant <= GRANT_IF;
            end else if (d_req && d_gnt) begin
                last_grant <= GRANT_D;
            end
            if_rvalid <= if_req & if_gnt;
            d_rvalid  <= d_req & d_gnt & ~d_we;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset corner case, then constrained-random
// traffic checked against a timestamp-based round-robin model and a shadow memory.
module tb_mem_port_arbiter;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int NVEC  = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [DW-1:0] mem_data, mem_q;
    logic [AW-1:0] mem_addr;
    logic          mem_we;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(int i);
        logic [DW-1:0] w;
        w = DW'(i * 257) ^ 16'hA5A5;
        return (i == 5) ? 16'hBEEF : w;
    endfunction

    // Single-port RAM with registered read address, reloaded on every reset edge.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_areg;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_data;
        end
        ram_areg <= mem_addr;
    end
    assign mem_q = ram[ram_areg];

    // Reference model state
    logic [DW-1:0] shadow [DEPTH];
    int            cyc, t_if, t_d;
    logic          m_ready;
    logic          e_irv, e_drv;
    logic [DW-1:0] e_ird, e_drd;
    // DUT values sampled mid-cycle by step
    logic          s_ig, s_dg, s_irv, s_drv;
    logic [DW-1:0] s_ird, s_drd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        t_if    = -2;   // fetch counts as older, so it wins the first contention
        t_d     = -1;
        m_ready = 1'b0;
        e_irv   = 1'b0;
        e_drv   = 1'b0;
        e_ird   = '0;
        e_drd   = '0;
    endtask

    // Called just after a rising edge; drives one cycle, checks mid-cycle, returns model grants.
    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        output logic gi, output logic gd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        gi = 1'b0;
        gd = 1'b0;
        if (!reset && m_ready) begin
            if (ir && dr) begin
                if (t_if < t_d) gi = 1'b1;
                else            gd = 1'b1;
            end else begin
                gi = ir;
                gd = dr;
            end
        end
        @(negedge clk);
        s_ig = if_gnt; s_dg = d_gnt; s_irv = if_rvalid; s_drv = d_rvalid;
        s_ird = if_rdata; s_drd = d_rdata;
        chk("if_gnt", if_gnt, gi);
        chk("d_gnt", d_gnt, gd);
        chk("mem_addr", mem_addr, gd ? da : ia);
        chk("mem_we", mem_we, dw & gd);
        chk("mem_data", mem_data, dd);
        chk("if_rvalid", if_rvalid, e_irv);
        chk("d_rvalid", d_rvalid, e_drv);
        if (e_irv) chk("if_rdata", if_rdata, e_ird);
        if (e_drv) chk("d_rdata", d_rdata, e_drd);
        @(posedge clk);
        #1;
        cyc++;
        e_irv = ir & gi;
        e_ird = shadow[ia];
        e_drv = dr & gd & ~dw;
        e_drd = shadow[da];
        if (dr && gd && dw) shadow[da] = dd;
        if (gi) t_if = cyc;
        if (gd) t_d = cyc;
        if (!reset) m_ready = 1'b1;
    endtask

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          eig;
        logic          edg;
        logic          eirv;
        logic          edrv;
        logic [DW-1:0] erd;
    } vec_t;

    function automatic vec_t mk(logic ir, logic [AW-1:0] ia, logic dr, logic dw,
                                logic [AW-1:0] da, logic [DW-1:0] dd, logic eig, logic edg,
                                logic eirv, logic edrv, logic [DW-1:0] erd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.eig = eig; v.edg = edg; v.eirv = eirv; v.edrv = edrv; v.erd = erd;
        return v;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return AW'($urandom);
        endcase
    endfunction

    vec_t vecs [NVEC];

    initial begin
        logic          gi, gd;
        logic          p_ir, p_dr, p_dw;
        logic [AW-1:0] p_ia, p_da;
        logic [DW-1:0] p_dd, w10, w20;

        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        cyc = 0;
        model_reset();
        w10 = init_word(16);
        w20 = init_word(32);

        //                ir ia      dr dw da      dd        ig dg irv drv rdata
        vecs[0]  = mk(1, 10'h005, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[1]  = mk(1, 10'h005, 0, 0, 10'h000, 16'h0000, 1, 0, 0, 0, 16'h0000);
        vecs[2]  = mk(0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 0, 1, 0, 16'hBEEF);
        vecs[3]  = mk(0, 10'h000, 1, 1, 10'h3FF, 16'h1234, 0, 1, 0, 0, 16'h0000);
        vecs[4]  = mk(0, 10'h000, 1, 0, 10'h3FF, 16'h0000, 0, 1, 0, 0, 16'h0000);
        vecs[5]  = mk(0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 1, 16'h1234);
        vecs[6]  = mk(1, 10'h010, 1, 0, 10'h020, 16'h0000, 1, 0, 0, 0, 16'h0000);
        vecs[7]  = mk(1, 10'h010, 1, 0, 10'h020, 16'h0000, 0, 1, 1, 0, w10);
        vecs[8]  = mk(1, 10'h010, 1, 0, 10'h020, 16'h0000, 1, 0, 0, 1, w20);
        vecs[9]  = mk(1, 10'h010, 1, 0, 10'h020, 16'h0000, 0, 1, 1, 0, w10);
        vecs[10] = mk(1, 10'h010, 1, 0, 10'h020, 16'h0000, 1, 0, 0, 1, w20);
        vecs[11] = mk(1, 10'h010, 1, 0, 10'h020, 16'h0000, 0, 1, 1, 0, w10);
        vecs[12] = mk(0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 1, w20);
        vecs[13] = mk(0, 10'h000, 1, 1, 10'h000, 16'h1111, 0, 1, 0, 0, 16'h0000);
        vecs[14] = mk(1, 10'h000, 1, 1, 10'h001, 16'h2222, 1, 0, 0, 0, 16'h0000);
        vecs[15] = mk(0, 10'h000, 1, 1, 10'h001, 16'h2222, 0, 1, 1, 0, 16'h1111);
        vecs[16] = mk(1, 10'h001, 0, 0, 10'h000, 16'h0000, 1, 0, 0, 0, 16'h0000);
        vecs[17] = mk(0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 0, 1, 0, 16'h2222);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd, gi, gd);
            chk($sformatf("vec%0d_if_gnt", i), s_ig, vecs[i].eig);
            chk($sformatf("vec%0d_d_gnt", i), s_dg, vecs[i].edg);
            chk($sformatf("vec%0d_if_rvalid", i), s_irv, vecs[i].eirv);
            chk($sformatf("vec%0d_d_rvalid", i), s_drv, vecs[i].edrv);
            if (vecs[i].eirv) chk($sformatf("vec%0d_if_rdata", i), s_ird, vecs[i].erd);
            if (vecs[i].edrv) chk($sformatf("vec%0d_d_rdata", i), s_drd, vecs[i].erd);
        end

        // Read accepted, then reset lands before its response edge.
        step(1'b1, 10'h007, 1'b0, 1'b0, 10'h000, 16'h0000, gi, gd);
        chk("pre_rst_if_rvalid", if_rvalid, 1'b1);
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h0AA;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_if_rvalid", if_rvalid, 1'b0);
        chk("mid_rst_d_rvalid", d_rvalid, 1'b0);
        chk("mid_rst_mem_we", mem_we, 1'b0);
        chk("mid_rst_if_gnt", if_gnt, 1'b0);
        chk("mid_rst_d_gnt", d_gnt, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 16'h0000, gi, gd);
        chk("rel_first_if_gnt", s_ig, 1'b0);
        chk("rel_first_d_gnt", s_dg, 1'b0);
        step(1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 16'h0000, gi, gd);
        chk("rel_second_if_gnt", s_ig, 1'b1);
        chk("rel_second_d_gnt", s_dg, 1'b0);
        step(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 16'h0000, gi, gd);
        chk("rel_third_d_gnt", s_dg, 1'b1);

        // Random traffic; each requester holds its request until granted.
        p_ir = 1'b0; p_dr = 1'b0; p_dw = 1'b0; p_ia = '0; p_da = '0; p_dd = '0;
        for (int c = 0; c < 500; c++) begin
            if (!p_ir) begin
                p_ir = ($urandom_range(0, 3) != 0);
                p_ia = rnd_addr();
            end
            if (!p_dr) begin
                p_dr = ($urandom_range(0, 3) != 0);
                p_dw = 1'($urandom_range(0, 1));
                p_da = rnd_addr();
                p_dd = DW'($urandom);
            end
            step(p_ir, p_ia, p_dr, p_dw, p_da, p_dd, gi, gd);
            if (gi) p_ir = 1'b0;
            if (gd) p_dr = 1'b0;
        end
        step(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h0000, gi, gd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the instruction-fetch port and the data load/store port of the MISC-V core onto the single-port synchronous RAM (raw_memory).
- Sits directly upstream of the RAM. It drives the RAM's data/addr/we and consumes its q.
- Tracks the RAM's one-cycle registered-address read latency and returns each read response to the port that issued it.
- Round-robin arbitration when both ports request in the same cycle.

Parameters:
- DATA_WIDTH, 16, word width; must match the RAM.
- ADDR_WIDTH, 10, word address width; must match the RAM.

Ports:
- clk  input  1  rising-edge clock; same clock as the RAM.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  instruction-fetch read request.
- if_addr  input  ADDR_WIDTH  fetch word address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  fetch read data valid this cycle.
- if_rdata  output  DATA_WIDTH  fetch read data.
- d_req  input  1  data-port request.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_WIDTH  data word address.
- d_wdata  input  DATA_WIDTH  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  load data valid this cycle; never asserted for stores.
- d_rdata  output  DATA_WIDTH  load data.
- mem_data  output  DATA_WIDTH  to RAM data.
- mem_addr  output  ADDR_WIDTH  to RAM addr.
- mem_we  output  1  to RAM we.
- mem_q  input  DATA_WIDTH  from RAM q.

Behaviour:
- Handshake:
  - A request is accepted on the rising edge of a cycle in which req and gnt are both high.
  - gnt is combinational from the req inputs and the arbiter state, in the same cycle.
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - At most one gnt is high per cycle.
- Arbitration:
  - Only one port requesting: that port gets gnt.
  - Both ports requesting: grant goes to the port NOT granted most recently.
  - last_grant is a 1-bit register. It updates only on an accepted request: 0 = fetch, 1 = data.
  - Reset value of last_grant is 1, so the first contended cycle after reset goes to fetch.
- RAM drive (combinational):
  - mem_addr = address of the granted port. With no grant, mem_addr = if_addr.
  - mem_we = d_we & d_gnt. It is forced 0 while reset is high.
  - mem_data = d_wdata at all times.
- Read latency:
  - A read accepted at edge N produces rvalid for that port during the cycle between edges N and N+1. This is exactly one cycle after gnt.
  - The RAM's q reflects the address registered at edge N during that cycle.
  - if_rvalid and d_rvalid are registered flags:
    - if_rvalid <= if_req & if_gnt.
    - d_rvalid <= d_req & d_gnt & ~d_we.
  - if_rdata = d_rdata = mem_q as a pass-through. rdata contents are don't-care when rvalid is low.
- Back-to-back:
  - A port can be granted every cycle. rvalid for request K overlaps gnt for request K+1.
  - Reads issued on alternating ports produce alternating rvalids, in order.
- Stores:
  - The store is committed at the accepting edge.
  - No response pulse.
  - A fetch of the same address granted on the next cycle returns the new data.
- Boundaries:
  - Address 0 and address 2**ADDR_WIDTH-1 are legal. There is no wrap or range checking.
  - Simultaneous requests to the same address are serialised by the round-robin order.
- Reset:
  - Asynchronous assertion immediately clears if_rvalid, d_rvalid and mem_we, and sets last_grant=1.
  - While reset is high: if_gnt=0, d_gnt=0.
  - A read accepted on the edge before reset asserts loses its rvalid; the requester must reissue it.
  - No grants occur on the first edge at which reset is sampled low. Grants resume from the following cycle.

Test Plan:
- Reset, then if_req=1 with if_addr=0x005 and RAM[5]=0xBEEF -> if_gnt=1 in the same cycle; if_rvalid=1 with if_rdata=0xBEEF the next cycle; d_rvalid stays 0.
- d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0x1234; next cycle d_we=0 read of 0x3FF -> mem_we pulses for one cycle, no d_rvalid for the store; the read returns d_rdata=0x1234 one cycle after its gnt.
- Both ports requesting continuously for 6 cycles, reads at 0x010/0x020 -> first gnt to fetch, then strict alternation d,if,d,if,d; rvalids alternate accordingly with correct data.
- Fetch request held while data stores stream, then data goes idle -> fetch granted no later than the second cycle of contention; fetch never starves.
- Read accepted, reset asserted mid-cycle before the response edge -> both rvalid outputs low immediately; mem_we=0; first grant after release goes to fetch when both ports request.
